// File: rtl/mii_pkg.sv
// mii_pkg: shared code points, FSM state and word-kind enums for the MII checker.
package mii_pkg;

    localparam logic [7:0] IDLE_CODE  = 8'h07;
    localparam logic [7:0] START_CODE = 8'hFB;
    localparam logic [7:0] TERM_CODE  = 8'hFD;
    localparam logic [7:0] DATA_BYTE  = 8'hAA;

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_t;

    typedef enum logic [2:0] {
        K_IDLE,
        K_START,
        K_DATA,
        K_TERM,
        K_INVALID
    } kind_t;

    // 16-bit add that sticks at 0xFFFF instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/mii_word_decode.sv
// mii_word_decode: combinational classifier for one received word.
// Reports the word kind, the terminate lane and whether every payload byte
// carried in the word equals DATA_BYTE.
module mii_word_decode
    import mii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int LANE_W     = $clog2(CTRL_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    output kind_t                 kind,
    output logic [LANE_W-1:0]     term_lane,
    output logic                  pat_ok
);

    localparam logic [CTRL_WIDTH-1:0] START_CTRL = CTRL_WIDTH'(1);

    int unsigned k;
    logic        found;
    logic        all_idle;
    logic        term_ok;
    logic        payload;

    // Classify the word; the lowest set ctrl bit is the terminate candidate
    always_comb begin
        all_idle = 1'b1;
        found    = 1'b0;
        k        = 0;
        term_ok  = 1'b0;
        payload  = 1'b0;
        pat_ok   = 1'b1;
        kind     = K_INVALID;

        for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
            if (data[8*i +: 8] != IDLE_CODE) all_idle = 1'b0;
            if (!found && ctrl[i]) begin
                found = 1'b1;
                k     = i;
            end
        end

        term_ok = found && (data[8*k +: 8] == TERM_CODE);
        for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
            if (i > k && data[8*i +: 8] != IDLE_CODE) term_ok = 1'b0;
        end

        if (&ctrl && all_idle)
            kind = K_IDLE;
        else if (ctrl == START_CTRL && data[7:0] == START_CODE)
            kind = K_START;
        else if (ctrl == '0)
            kind = K_DATA;
        else if (term_ok)
            kind = K_TERM;

        for (int unsigned i = 0; i < CTRL_WIDTH; i++) begin
            payload = (kind == K_START && i >= 1) || (kind == K_DATA) ||
                      (kind == K_TERM && i < k);
            if (payload && data[8*i +: 8] != DATA_BYTE) pat_ok = 1'b0;
        end

        term_lane = LANE_W'(k);
    end

endmodule

// File: rtl/mii_checker.sv
// mii_checker: frames received MII words (IDLE / START / DATA / TERM),
// reports good-frame length and count, and flags protocol errors.
// Optional payload-pattern check: define MII_CHECKER_PATTERN_CHK_EN.
module mii_checker
    import mii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int MAX_WORDS  = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_frame_valid,
    output logic [15:0]           o_frame_len,
    output logic [31:0]           o_frame_cnt,
    output logic                  o_err,
    output logic [15:0]           o_err_cnt,
    output logic                  o_in_frame
);

    localparam int LANE_W = $clog2(CTRL_WIDTH);
    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

`ifdef MII_CHECKER_PATTERN_CHK_EN
    localparam logic PAT_EN = 1'b1;
`else
    localparam logic PAT_EN = 1'b0;
`endif

    kind_t             kind;
    logic [LANE_W-1:0] term_lane;
    logic              pat_ok;
    logic              pat_bad;

    state_t      state, state_nx;
    logic        synced, synced_nx;
    logic [15:0] len, len_nx;
    logic [15:0] wcnt, wcnt_nx;
    logic        good, bad;

    mii_word_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_decode (
        .data      (i_rx_data),
        .ctrl      (i_rx_ctrl),
        .kind      (kind),
        .term_lane (term_lane),
        .pat_ok    (pat_ok)
    );

    assign pat_bad    = PAT_EN && !pat_ok;
    assign o_in_frame = (state == ST_PAYLOAD);

    // Next-state, length/word accounting and good/bad word decision
    always_comb begin
        state_nx  = state;
        synced_nx = synced;
        len_nx    = len;
        wcnt_nx   = wcnt;
        good      = 1'b0;
        bad       = 1'b0;

        if (!synced) begin
            if (kind == K_IDLE) synced_nx = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (kind)
                        K_IDLE: ;
                        K_START: begin
                            if (pat_bad) begin
                                bad = 1'b1;
                            end else begin
                                state_nx = ST_PAYLOAD;
                                len_nx   = 16'(CTRL_WIDTH - 1);
                                wcnt_nx  = 16'd1;
                            end
                        end
                        default: bad = 1'b1;
                    endcase
                end
                ST_PAYLOAD: begin
                    case (kind)
                        K_DATA: begin
                            // this word is number wcnt+1; reaching MAX_W without TERM is oversize
                            if (pat_bad || wcnt >= MAX_W - 16'd1) begin
                                bad      = 1'b1;
                                state_nx = ST_IDLE;
                            end else begin
                                len_nx  = sat_add16(len, 16'(CTRL_WIDTH));
                                wcnt_nx = wcnt + 16'd1;
                            end
                        end
                        K_TERM: begin
                            state_nx = ST_IDLE;
                            if (pat_bad) begin
                                bad = 1'b1;
                            end else begin
                                good   = 1'b1;
                                len_nx = sat_add16(len, 16'(term_lane));
                            end
                        end
                        default: begin
                            bad      = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    endcase
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // FSM state, sync flag and per-frame accumulators
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            synced <= 1'b0;
            len    <= '0;
            wcnt   <= '0;
        end else begin
            state  <= state_nx;
            synced <= synced_nx;
            len    <= len_nx;
            wcnt   <= wcnt_nx;
        end
    end

    // Registered result pulses and saturating counters
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_valid <= 1'b0;
            o_frame_len   <= '0;
            o_frame_cnt   <= '0;
            o_err         <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            o_frame_valid <= good;
            o_err         <= bad;
            if (good) o_frame_len <= len_nx;
            if (good && o_frame_cnt != '1) o_frame_cnt <= o_frame_cnt + 32'd1;
            if (bad && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mii_checker.sv
// tb_mii_checker: directed scoreboard bench for mii_checker.
// Two instances: default MAX_WORDS and MAX_WORDS=4 for the oversize path.
module tb_mii_checker;
    import mii_pkg::*;

    typedef struct packed {
        logic        fv;
        logic [15:0] len;
        logic [31:0] cnt;
        logic        err;
        logic [15:0] ecnt;
        logic        inf;
    } exp_t;

    localparam logic [63:0] W_IDLE  = {8{IDLE_CODE}};
    localparam logic [63:0] W_START = {{7{DATA_BYTE}}, START_CODE};
    localparam logic [63:0] W_DATA  = {8{DATA_BYTE}};
    localparam logic [63:0] W_BAD   = 64'hAAAAAAAA55AAAAAA;
    localparam logic [63:0] W_INV   = 64'h1122334455667788;

    logic        clk;
    logic        rst_n;
    logic [63:0] rx_data, rx_data4;
    logic [7:0]  rx_ctrl, rx_ctrl4;

    logic        fv, fv4, err, err4, inf, inf4;
    logic [15:0] flen, flen4, ecnt, ecnt4;
    logic [31:0] fcnt, fcnt4;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    exp_t exp4_q[$];

    mii_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .MAX_WORDS(32)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_ctrl(rx_ctrl),
        .o_frame_valid(fv), .o_frame_len(flen), .o_frame_cnt(fcnt),
        .o_err(err), .o_err_cnt(ecnt), .o_in_frame(inf)
    );

    mii_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .MAX_WORDS(4)) dut4 (
        .clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data4), .i_rx_ctrl(rx_ctrl4),
        .o_frame_valid(fv4), .o_frame_len(flen4), .o_frame_cnt(fcnt4),
        .o_err(err4), .o_err_cnt(ecnt4), .o_in_frame(inf4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t e(input logic f, input logic [15:0] l, input logic [31:0] c,
                               input logic er, input logic [15:0] ec, input logic in_f);
        exp_t x;
        x.fv = f; x.len = l; x.cnt = c; x.err = er; x.ecnt = ec; x.inf = in_f;
        return x;
    endfunction

    function automatic logic [63:0] term_d(input int k);
        logic [63:0] d;
        for (int i = 0; i < 8; i++)
            d[8*i +: 8] = (i < k) ? DATA_BYTE : ((i == k) ? TERM_CODE : IDLE_CODE);
        return d;
    endfunction

    function automatic logic [7:0] term_c(input int k);
        logic [7:0] c;
        c = 8'hFF << k;
        return c;
    endfunction

    task automatic cmp1(input string tag, input string fld, input logic [31:0] got,
                        input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s.%s: got %0h expected %0h", tag, fld, got, want);
        end
    endtask

    task automatic cmp_all(input string tag, input bit sel, input exp_t x);
        if (sel) begin
            cmp1(tag, "frame_valid", 32'(fv4),  32'(x.fv));
            cmp1(tag, "frame_len",   32'(flen4), 32'(x.len));
            cmp1(tag, "frame_cnt",   fcnt4,      x.cnt);
            cmp1(tag, "err",         32'(err4), 32'(x.err));
            cmp1(tag, "err_cnt",     32'(ecnt4), 32'(x.ecnt));
            cmp1(tag, "in_frame",    32'(inf4), 32'(x.inf));
        end else begin
            cmp1(tag, "frame_valid", 32'(fv),   32'(x.fv));
            cmp1(tag, "frame_len",   32'(flen), 32'(x.len));
            cmp1(tag, "frame_cnt",   fcnt,      x.cnt);
            cmp1(tag, "err",         32'(err),  32'(x.err));
            cmp1(tag, "err_cnt",     32'(ecnt), 32'(x.ecnt));
            cmp1(tag, "in_frame",    32'(inf),  32'(x.inf));
        end
    endtask

    task automatic step(input string tag, input logic [63:0] d, input logic [7:0] c, input exp_t x);
        rx_data = d;
        rx_ctrl = c;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            cmp_all(tag, 1'b0, exp_q.pop_front());
        end
    endtask

    task automatic step4(input string tag, input logic [63:0] d, input logic [7:0] c, input exp_t x);
        rx_data4 = d;
        rx_ctrl4 = c;
        exp4_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp4_q.size() == 0) begin
            fails++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            cmp_all(tag, 1'b1, exp4_q.pop_front());
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_ctrl  = '0;
        rx_data4 = W_IDLE;
        rx_ctrl4 = 8'hFF;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        cmp_all("reset", 1'b0, e(0, 0, 0, 0, 0, 0));
        cmp_all("reset4", 1'b1, e(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // unsynced: DATA and START ignored without error
        step("unsync_d0", '0, 8'h00, e(0, 0, 0, 0, 0, 0));
        step("unsync_d1", '0, 8'h00, e(0, 0, 0, 0, 0, 0));
        step("unsync_st", W_START, 8'h01, e(0, 0, 0, 0, 0, 0));

        // basic frame: 3 IDLE, START, 2 DATA, TERM(3)
        step("idle0", W_IDLE, 8'hFF, e(0, 0, 0, 0, 0, 0));
        step("idle1", W_IDLE, 8'hFF, e(0, 0, 0, 0, 0, 0));
        step("idle2", W_IDLE, 8'hFF, e(0, 0, 0, 0, 0, 0));
        step("f1_start", W_START, 8'h01, e(0, 0, 0, 0, 0, 1));
        step("f1_d0", W_DATA, 8'h00, e(0, 0, 0, 0, 0, 1));
        step("f1_d1", W_DATA, 8'h00, e(0, 0, 0, 0, 0, 1));
        step("f1_term3", term_d(3), term_c(3), e(1, 26, 1, 0, 0, 0));
        step("f1_after", W_IDLE, 8'hFF, e(0, 26, 1, 0, 0, 0));

        // back-to-back: START TERM(0) START TERM(7)
        step("b2b_s0", W_START, 8'h01, e(0, 26, 1, 0, 0, 1));
        step("b2b_t0", term_d(0), term_c(0), e(1, 7, 2, 0, 0, 0));
        step("b2b_s1", W_START, 8'h01, e(0, 7, 2, 0, 0, 1));
        step("b2b_t7", term_d(7), term_c(7), e(1, 14, 3, 0, 0, 0));
        step("b2b_idle", W_IDLE, 8'hFF, e(0, 14, 3, 0, 0, 0));

        // START inside a frame aborts it
        step("abort_s", W_START, 8'h01, e(0, 14, 3, 0, 0, 1));
        step("abort_d", W_DATA, 8'h00, e(0, 14, 3, 0, 0, 1));
        step("abort_s2", W_START, 8'h01, e(0, 14, 3, 1, 1, 0));
        step("abort_idle", W_IDLE, 8'hFF, e(0, 14, 3, 0, 1, 0));

        // errors while idle: INVALID and DATA
        step("idle_inv", W_INV, 8'h0F, e(0, 14, 3, 1, 2, 0));
        step("idle_data", W_DATA, 8'h00, e(0, 14, 3, 1, 3, 0));
        step("idle_ok", W_IDLE, 8'hFF, e(0, 14, 3, 0, 3, 0));

        // reset mid-frame
        step("rst_s", W_START, 8'h01, e(0, 14, 3, 0, 3, 1));
        step("rst_d", W_DATA, 8'h00, e(0, 14, 3, 0, 3, 1));
        rst_n = 1'b0;
        #1;
        cmp_all("rst_mid", 1'b0, e(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        cmp_all("rst_held", 1'b0, e(0, 0, 0, 0, 0, 0));
        rx_data = '0;
        rx_ctrl = '0;
        rst_n   = 1'b1;
        step("rst_z0", '0, 8'h00, e(0, 0, 0, 0, 0, 0));
        step("rst_z1", '0, 8'h00, e(0, 0, 0, 0, 0, 0));
        step("rst_idle", W_IDLE, 8'hFF, e(0, 0, 0, 0, 0, 0));
        step("rst_f_s", W_START, 8'h01, e(0, 0, 0, 0, 0, 1));
        step("rst_f_t1", term_d(1), term_c(1), e(1, 8, 1, 0, 0, 0));
        step("rst_f_idle", W_IDLE, 8'hFF, e(0, 8, 1, 0, 0, 0));

        // payload pattern: one DATA lane = 0x55
        step("pat_s", W_START, 8'h01, e(0, 8, 1, 0, 0, 1));
`ifdef MII_CHECKER_PATTERN_CHK_EN
        step("pat_bad", W_BAD, 8'h00, e(0, 8, 1, 1, 1, 0));
        step("pat_t2", term_d(2), term_c(2), e(0, 8, 1, 1, 2, 0));
        step("pat_idle", W_IDLE, 8'hFF, e(0, 8, 1, 0, 2, 0));
`else
        step("pat_bad", W_BAD, 8'h00, e(0, 8, 1, 0, 0, 1));
        step("pat_t2", term_d(2), term_c(2), e(1, 17, 2, 0, 0, 0));
        step("pat_idle", W_IDLE, 8'hFF, e(0, 17, 2, 0, 0, 0));
`endif

        // oversize on MAX_WORDS=4 instance; dut input held at IDLE
        rx_data = W_IDLE;
        rx_ctrl = 8'hFF;
        step4("ovs_s", W_START, 8'h01, e(0, 0, 0, 0, 0, 1));
        step4("ovs_d2", W_DATA, 8'h00, e(0, 0, 0, 0, 0, 1));
        step4("ovs_d3", W_DATA, 8'h00, e(0, 0, 0, 0, 0, 1));
        step4("ovs_d4", W_DATA, 8'h00, e(0, 0, 0, 1, 1, 0));
        step4("ovs_d5", W_DATA, 8'h00, e(0, 0, 0, 1, 2, 0));
        step4("ovs_d6", W_DATA, 8'h00, e(0, 0, 0, 1, 3, 0));
        step4("ovs_idle", W_IDLE, 8'hFF, e(0, 0, 0, 0, 3, 0));
        // TERM exactly at word MAX_WORDS is still a good frame
        step4("max_s", W_START, 8'h01, e(0, 0, 0, 0, 3, 1));
        step4("max_d2", W_DATA, 8'h00, e(0, 0, 0, 0, 3, 1));
        step4("max_d3", W_DATA, 8'h00, e(0, 0, 0, 0, 3, 1));
        step4("max_t0", term_d(0), term_c(0), e(1, 23, 1, 0, 3, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
